// File: rtl/umi_combiner.sv
// rtl/umi_combiner.sv - UMI response/request combiner with registered output and anti-starvation
module umi_combiner #(
  parameter int AW     = 64,
  parameter int CW     = 32,
  parameter int UW     = 256,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          umi_resp_in_valid,
  input  logic [CW-1:0] umi_resp_in_cmd,
  input  logic [AW-1:0] umi_resp_in_dst_addr,
  input  logic [AW-1:0] umi_resp_in_src_addr,
  input  logic [UW-1:0] umi_resp_in_payload,
  output logic          umi_resp_in_ready,
  input  logic          umi_req_in_valid,
  input  logic [CW-1:0] umi_req_in_cmd,
  input  logic [AW-1:0] umi_req_in_dst_addr,
  input  logic [AW-1:0] umi_req_in_src_addr,
  input  logic [UW-1:0] umi_req_in_payload,
  output logic          umi_req_in_ready,
  output logic          umi_out_valid,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dst_addr,
  output logic [AW-1:0] umi_out_src_addr,
  output logic [UW-1:0] umi_out_payload,
  input  logic          umi_out_ready
);

  localparam int              CNTW      = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
  localparam logic [CNTW-1:0] LP_STARVE = CNTW'(STARVE);

  logic            r_out_valid;
  logic [CW-1:0]   r_out_cmd;
  logic [AW-1:0]   r_out_dst_addr;
  logic [AW-1:0]   r_out_src_addr;
  logic [UW-1:0]   r_out_payload;
  logic [CNTW-1:0] r_cnt;

  logic w_load;
  logic w_starved;
  logic w_grant_resp;
  logic w_grant_req;
  logic w_resp_xfer;
  logic w_req_xfer;

  assign w_load = ~r_out_valid | umi_out_ready;

  // A waiting request overtakes responses once it has been passed over STARVE times.
  assign w_starved    = (STARVE > 0) && (r_cnt == LP_STARVE);
  assign w_grant_resp = umi_resp_in_valid & ~(umi_req_in_valid & w_starved);
  assign w_grant_req  = umi_req_in_valid & (~umi_resp_in_valid | w_starved);

  assign umi_resp_in_ready = w_load & w_grant_resp & nreset;
  assign umi_req_in_ready  = w_load & w_grant_req & nreset;

  assign w_resp_xfer = umi_resp_in_valid & umi_resp_in_ready;
  assign w_req_xfer  = umi_req_in_valid & umi_req_in_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_out_valid    <= 1'b0;
      r_out_cmd      <= '0;
      r_out_dst_addr <= '0;
      r_out_src_addr <= '0;
      r_out_payload  <= '0;
    end else if (w_load) begin
      r_out_valid <= w_resp_xfer | w_req_xfer;
      if (w_req_xfer) begin
        r_out_cmd      <= umi_req_in_cmd;
        r_out_dst_addr <= umi_req_in_dst_addr;
        r_out_src_addr <= umi_req_in_src_addr;
        r_out_payload  <= umi_req_in_payload;
      end else if (w_resp_xfer) begin
        r_out_cmd      <= umi_resp_in_cmd;
        r_out_dst_addr <= umi_resp_in_dst_addr;
        r_out_src_addr <= umi_resp_in_src_addr;
        r_out_payload  <= umi_resp_in_payload;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt <= '0;
    end else if (w_resp_xfer && umi_req_in_valid) begin
      if (r_cnt != LP_STARVE) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (w_req_xfer || !umi_req_in_valid) begin
      r_cnt <= '0;
    end
  end

  assign umi_out_valid    = r_out_valid;
  assign umi_out_cmd      = r_out_cmd;
  assign umi_out_dst_addr = r_out_dst_addr;
  assign umi_out_src_addr = r_out_src_addr;
  assign umi_out_payload  = r_out_payload;

endmodule

// File: tb/tb_umi_combiner.sv
// tb/tb_umi_combiner.sv - directed self-checking bench for umi_combiner
module tb_umi_combiner;

  localparam int AW = 64;
  localparam int CW = 32;
  localparam int UW = 256;

  localparam logic [CW-1:0] RESP_CMD = 32'hC0DE_0001;
  localparam logic [CW-1:0] REQ_CMD  = 32'hC0DE_0002;
  localparam logic [AW-1:0] RESP_DST = 64'h0000_1111_0000_1111;
  localparam logic [AW-1:0] REQ_DST  = 64'h0000_2222_0000_2222;
  localparam logic [AW-1:0] RESP_SRC = 64'h0000_3333;
  localparam logic [AW-1:0] REQ_SRC  = 64'h0000_4444;

  logic          clk = 1'b0;
  logic          nreset;

  logic          resp_valid, req_valid, out_ready;
  logic [CW-1:0] resp_cmd, req_cmd;
  logic [AW-1:0] resp_dst, resp_src, req_dst, req_src;
  logic [UW-1:0] resp_payload, req_payload;
  logic          resp_ready, req_ready, out_valid;
  logic [CW-1:0] out_cmd;
  logic [AW-1:0] out_dst, out_src;
  logic [UW-1:0] out_payload;

  logic          s_resp_valid, s_req_valid, s_out_ready;
  logic          s_resp_ready, s_req_ready, s_out_valid;
  logic [CW-1:0] s_out_cmd;
  logic [AW-1:0] s_out_dst, s_out_src;
  logic [UW-1:0] s_out_payload;

  int checks   = 0;
  int failures = 0;
  int n_req;

  always #5 clk = ~clk;

  umi_combiner #(.AW(AW), .CW(CW), .UW(UW), .STARVE(4)) u_dut (
    .clk                  (clk),
    .nreset               (nreset),
    .umi_resp_in_valid    (resp_valid),
    .umi_resp_in_cmd      (resp_cmd),
    .umi_resp_in_dst_addr (resp_dst),
    .umi_resp_in_src_addr (resp_src),
    .umi_resp_in_payload  (resp_payload),
    .umi_resp_in_ready    (resp_ready),
    .umi_req_in_valid     (req_valid),
    .umi_req_in_cmd       (req_cmd),
    .umi_req_in_dst_addr  (req_dst),
    .umi_req_in_src_addr  (req_src),
    .umi_req_in_payload   (req_payload),
    .umi_req_in_ready     (req_ready),
    .umi_out_valid        (out_valid),
    .umi_out_cmd          (out_cmd),
    .umi_out_dst_addr     (out_dst),
    .umi_out_src_addr     (out_src),
    .umi_out_payload      (out_payload),
    .umi_out_ready        (out_ready)
  );

  umi_combiner #(.AW(AW), .CW(CW), .UW(UW), .STARVE(0)) u_dut_strict (
    .clk                  (clk),
    .nreset               (nreset),
    .umi_resp_in_valid    (s_resp_valid),
    .umi_resp_in_cmd      (RESP_CMD),
    .umi_resp_in_dst_addr (RESP_DST),
    .umi_resp_in_src_addr (RESP_SRC),
    .umi_resp_in_payload  (256'h1),
    .umi_resp_in_ready    (s_resp_ready),
    .umi_req_in_valid     (s_req_valid),
    .umi_req_in_cmd       (REQ_CMD),
    .umi_req_in_dst_addr  (REQ_DST),
    .umi_req_in_src_addr  (REQ_SRC),
    .umi_req_in_payload   (256'h2),
    .umi_req_in_ready     (s_req_ready),
    .umi_out_valid        (s_out_valid),
    .umi_out_cmd          (s_out_cmd),
    .umi_out_dst_addr     (s_out_dst),
    .umi_out_src_addr     (s_out_src),
    .umi_out_payload      (s_out_payload),
    .umi_out_ready        (s_out_ready)
  );

  task automatic chk(input string tag, input logic [UW-1:0] obs, input logic [UW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset       = 1'b0;
    resp_cmd     = RESP_CMD;
    resp_dst     = RESP_DST;
    resp_src     = RESP_SRC;
    resp_payload = 256'h77;
    req_cmd      = REQ_CMD;
    req_dst      = REQ_DST;
    req_src      = REQ_SRC;
    req_payload  = 256'h88;
    resp_valid   = 1'b1;
    req_valid    = 1'b1;
    out_ready    = 1'b1;
    s_resp_valid = 1'b0;
    s_req_valid  = 1'b0;
    s_out_ready  = 1'b1;

    // Reset with both inputs valid
    #1;
    chk("rst_out_valid", {255'b0, out_valid}, 256'h0);
    chk("rst_out_payload", out_payload, 256'h0);
    chk("rst_out_cmd", {224'b0, out_cmd}, 256'h0);
    chk("rst_resp_ready", {255'b0, resp_ready}, 256'h0);
    chk("rst_req_ready", {255'b0, req_ready}, 256'h0);
    tick();
    tick();
    chk("rst_hold_valid", {255'b0, out_valid}, 256'h0);

    // Single response stream, 8 back-to-back packets
    @(negedge clk);
    req_valid    = 1'b0;
    resp_payload = 256'h0;
    nreset       = 1'b1;
    #1;
    chk("single_resp_ready", {255'b0, resp_ready}, 256'h1);
    for (int i = 0; i < 8; i++) begin
      resp_payload = UW'(i);
      tick();
      chk($sformatf("single_valid_%0d", i), {255'b0, out_valid}, 256'h1);
      chk($sformatf("single_payload_%0d", i), out_payload, UW'(i));
    end
    chk("single_cmd", {224'b0, out_cmd}, {224'b0, RESP_CMD});
    chk("single_dst", {192'b0, out_dst}, {192'b0, RESP_DST});
    resp_valid = 1'b0;
    tick();
    chk("single_drain_valid", {255'b0, out_valid}, 256'h0);

    // Starvation: resp,resp,resp,resp,req repeating
    resp_valid = 1'b1;
    req_valid  = 1'b1;
    n_req      = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("starve_cmd_%0d", k), {224'b0, out_cmd},
          {224'b0, ((k % 5) == 4) ? REQ_CMD : RESP_CMD});
      if (out_cmd == REQ_CMD) n_req++;
    end
    chk("starve_req_count", 256'(n_req), 256'd2);
    chk("starve_req_src", {192'b0, out_src}, {192'b0, REQ_SRC});

    // Backpressure holds packet A
    req_valid    = 1'b0;
    resp_payload = 256'hA5;
    tick();
    chk("bp_load_a", out_payload, 256'hA5);
    out_ready    = 1'b0;
    resp_payload = 256'h5A;
    req_valid    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_resp_ready_%0d", k), {255'b0, resp_ready}, 256'h0);
      chk($sformatf("bp_req_ready_%0d", k), {255'b0, req_ready}, 256'h0);
      tick();
      chk($sformatf("bp_hold_payload_%0d", k), out_payload, 256'hA5);
      chk($sformatf("bp_hold_valid_%0d", k), {255'b0, out_valid}, 256'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_resp_ready", {255'b0, resp_ready}, 256'h1);
    chk("bp_release_req_ready", {255'b0, req_ready}, 256'h0);
    tick();
    chk("bp_next_payload", out_payload, 256'h5A);
    resp_valid = 1'b0;
    req_valid  = 1'b0;
    tick();
    chk("bp_drain_valid", {255'b0, out_valid}, 256'h0);

    // Strict priority, STARVE = 0
    s_resp_valid = 1'b1;
    s_req_valid  = 1'b1;
    n_req        = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("strict_req_ready_%0d", k), {255'b0, s_req_ready}, 256'h0);
      tick();
      chk($sformatf("strict_cmd_%0d", k), {224'b0, s_out_cmd}, {224'b0, RESP_CMD});
      if (s_out_cmd == REQ_CMD) n_req++;
    end
    chk("strict_req_count", 256'(n_req), 256'd0);
    s_resp_valid = 1'b0;
    #1;
    chk("strict_drop_req_ready", {255'b0, s_req_ready}, 256'h1);
    tick();
    chk("strict_drop_cmd", {224'b0, s_out_cmd}, {224'b0, REQ_CMD});
    chk("strict_drop_payload", s_out_payload, 256'h2);
    s_req_valid = 1'b0;

    // Reset mid-stream: counter must restart from zero
    resp_payload = 256'h33;
    resp_valid   = 1'b1;
    req_valid    = 1'b1;
    tick();
    tick();
    chk("midrst_pre_valid", {255'b0, out_valid}, 256'h1);
    #2;
    nreset = 1'b0;
    #1;
    chk("midrst_valid", {255'b0, out_valid}, 256'h0);
    chk("midrst_payload", out_payload, 256'h0);
    chk("midrst_resp_ready", {255'b0, resp_ready}, 256'h0);
    @(negedge clk);
    nreset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("midrst_cmd_%0d", k), {224'b0, out_cmd},
          {224'b0, (k == 4) ? REQ_CMD : RESP_CMD});
    end
    resp_valid = 1'b0;
    req_valid  = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
